pc_sequencer: RTL and testbench

Multi-cycle program-counter controller for the MIPS core. It owns the PC and the instruction register, and drives the instruction-memory fetch handshake. It holds each instruction until the execute side signals completion, then selects the next PC by fixed priority: exception, eret, jr, j/jal, branch, sequential. It also keeps the EPC register, a halt state and a retired-instruction counter.

---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/pc_sequencer_npc_select.sv | 61 ++++++
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer: FSM states, next-PC
// select codes, reset/exception addresses and the branch offset helper.
package pc_seq_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    NPC_EXC  = 3'd0,
    NPC_ERET = 3'd1,
    NPC_JR   = 3'd2,
    NPC_J    = 3'd3,
    NPC_BR   = 3'd4,
    NPC_SEQ  = 3'd5
  } npc_sel_t;

  // Word offset to byte offset, sign-extended to 32 bits.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_npc_select.sv
// Combinational next-PC selection by fixed priority:
// exception, eret, jr, j/jal, branch, sequential.
module npc_select
  import pc_seq_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_epc,
  input  logic [31:0] i_exc_vector,
  input  logic        i_exc_req,
  input  logic        i_eret,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  input  logic        i_jmp,
  input  logic [25:0] i_jmp_target,
  input  logic        i_br_taken,
  input  logic [15:0] i_br_imm,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc_plus4,
  output npc_sel_t    o_sel,
  output logic        o_exc
);

  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = i_pc + 32'd4;
  assign o_pc_plus4 = w_pc_plus4;

  // Priority chain; a misaligned jr target is folded into exception entry.
  always_comb begin
    o_next_pc = w_pc_plus4;
    o_sel     = NPC_SEQ;
    o_exc     = 1'b0;
    if (i_exc_req) begin
      o_next_pc = i_exc_vector;
      o_sel     = NPC_EXC;
      o_exc     = 1'b1;
    end else if (i_eret) begin
      o_next_pc = i_epc;
      o_sel     = NPC_ERET;
    end else if (i_jr) begin
      if (i_jr_target[1:0] != 2'b00) begin
        o_next_pc = i_exc_vector;
        o_sel     = NPC_EXC;
        o_exc     = 1'b1;
      end else begin
        o_next_pc = i_jr_target;
        o_sel     = NPC_JR;
      end
    end else if (i_jmp) begin
      o_next_pc = {w_pc_plus4[31:28], i_jmp_target, 2'b00};
      o_sel     = NPC_J;
    end else if (i_br_taken) begin
      o_next_pc = w_pc_plus4 + branch_offset(i_br_imm);
      o_sel     = NPC_BR;
    end else begin
      o_next_pc = w_pc_plus4;
      o_sel     = NPC_SEQ;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: fetch handshake, instruction hold until
// ex_done, next-PC update, EPC, halt state and retired-instruction counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = pc_seq_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = pc_seq_pkg::EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ir,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  input  logic        i_ex_done,
  input  logic        i_br_taken,
  input  logic [15:0] i_br_imm,
  input  logic        i_jmp,
  input  logic [25:0] i_jmp_target,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  input  logic        i_exc_req,
  input  logic        i_eret,
  input  logic        i_halt_req,
  output logic [31:0] o_epc,
  output logic        o_exc_taken,
  output logic        o_halted,
  output logic [31:0] o_retired
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_epc;
  logic [31:0] r_retired;
  logic        r_exc_taken;

  logic        w_imem_req;
  logic        w_instr_valid;
  logic        w_halted;
  logic        w_fetch_done;
  logic        w_retire;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus4;
  npc_sel_t    w_sel;
  logic        w_exc;

  npc_select u_npc_select (
    .i_pc         (r_pc),
    .i_epc        (r_epc),
    .i_exc_vector (EXC_VECTOR),
    .i_exc_req    (i_exc_req),
    .i_eret       (i_eret),
    .i_jr         (i_jr),
    .i_jr_target  (i_jr_target),
    .i_jmp        (i_jmp),
    .i_jmp_target (i_jmp_target),
    .i_br_taken   (i_br_taken),
    .i_br_imm     (i_br_imm),
    .o_next_pc    (w_next_pc),
    .o_pc_plus4   (w_pc_plus4),
    .o_sel        (w_sel),
    .o_exc        (w_exc)
  );

  assign w_fetch_done = (r_state == S_FETCH) && i_imem_ack;
  assign w_retire     = (r_state == S_EXEC) && i_ex_done;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_imem_req    = 1'b0;
    w_instr_valid = 1'b0;
    w_halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        w_instr_valid = 1'b1;
        if (!i_ex_done) begin
          w_state_nxt = S_EXEC;
        end else if (i_halt_req && !w_exc) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        w_halted    = 1'b1;
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Architectural registers: IR on fetch, PC/EPC/retired on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_ir        <= 32'h0000_0000;
      r_epc       <= 32'h0000_0000;
      r_retired   <= 32'h0000_0000;
      r_exc_taken <= 1'b0;
    end else begin
      r_exc_taken <= 1'b0;
      if (w_fetch_done) begin
        r_ir <= i_imem_rdata;
      end
      if (w_retire) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
        if (w_sel == NPC_EXC) begin
          r_epc <= r_pc;
        end
        r_exc_taken <= w_exc;
      end
    end
  end

  assign o_imem_req    = w_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_ir          = r_ir;
  assign o_instr_valid = w_instr_valid;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_epc         = r_epc;
  assign o_exc_taken   = r_exc_taken;
  assign o_halted      = w_halted;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a reference model pushes expected
// post-completion state into a scoreboard queue, popped after each ex_done edge.
module tb_pc_sequencer;

  localparam logic [31:0] T_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] T_EXC_VEC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ex_done;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jmp;
  logic [25:0] jmp_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret;
  logic        halt_req;
  logic [31:0] epc;
  logic        exc_taken;
  logic        halted;
  logic [31:0] retired;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] retired;
    logic        exc;
    logic        halted;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_ret;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .o_ir          (ir),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .o_pc_plus4    (pc_plus4),
    .i_ex_done     (ex_done),
    .i_br_taken    (br_taken),
    .i_br_imm      (br_imm),
    .i_jmp         (jmp),
    .i_jmp_target  (jmp_target),
    .i_jr          (jr),
    .i_jr_target   (jr_target),
    .i_exc_req     (exc_req),
    .i_eret        (eret),
    .i_halt_req    (halt_req),
    .o_epc         (epc),
    .o_exc_taken   (exc_taken),
    .o_halted      (halted),
    .o_retired     (retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    ex_done    = 1'b0;
    br_taken   = 1'b0;
    br_imm     = 16'h0000;
    jmp        = 1'b0;
    jmp_target = 26'h000_0000;
    jr         = 1'b0;
    jr_target  = 32'h0000_0000;
    exc_req    = 1'b0;
    eret       = 1'b0;
    halt_req   = 1'b0;
  endtask

  task automatic model_reset();
    m_pc  = T_RESET_PC;
    m_epc = 32'h0000_0000;
    m_ret = 32'h0000_0000;
  endtask

  // Fetch with 'stall' un-acked cycles; ex_done is held high to show it is ignored.
  task automatic do_fetch(input int stall, input logic [31:0] data);
    for (int i = 0; i < stall; i++) begin
      imem_ack = 1'b0;
      ex_done  = 1'b1;
      check_eq("fetch_req_stall", {31'd0, imem_req}, 32'd1);
      check_eq("fetch_addr_stall", imem_addr, m_pc);
      step();
    end
    ex_done    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
    check_eq("fetch_addr", imem_addr, m_pc);
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check_eq("exec_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("exec_req", {31'd0, imem_req}, 32'd0);
    check_eq("exec_ir", ir, data);
    check_eq("exc_taken_cleared", {31'd0, exc_taken}, 32'd0);
  endtask

  // Execute: wait_cyc cycles without ex_done, then complete with the given controls.
  task automatic do_exec(input int wait_cyc, input logic x_exc, input logic x_eret,
                         input logic x_jr, input logic [31:0] x_jrt, input logic x_jmp,
                         input logic [25:0] x_jt, input logic x_br, input logic [15:0] x_bi,
                         input logic x_halt);
    exp_t        e;
    logic [31:0] p4;
    logic        exc;
    logic [31:0] npc;
    exc_req = x_exc;  eret = x_eret;  jr = x_jr;  jr_target = x_jrt;
    jmp = x_jmp;  jmp_target = x_jt;  br_taken = x_br;  br_imm = x_bi;
    halt_req = x_halt;
    imem_ack = 1'b1;
    for (int i = 0; i < wait_cyc; i++) begin
      ex_done = 1'b0;
      step();
      check_eq("stall_pc", pc, m_pc);
      check_eq("stall_retired", retired, m_ret);
      check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    p4  = m_pc + 32'd4;
    exc = 1'b0;
    if (x_exc) begin
      npc = T_EXC_VEC; exc = 1'b1;
    end else if (x_eret) begin
      npc = m_epc;
    end else if (x_jr && (x_jrt[1:0] != 2'b00)) begin
      npc = T_EXC_VEC; exc = 1'b1;
    end else if (x_jr) begin
      npc = x_jrt;
    end else if (x_jmp) begin
      npc = {p4[31:28], x_jt, 2'b00};
    end else if (x_br) begin
      npc = p4 + {{14{x_bi[15]}}, x_bi, 2'b00};
    end else begin
      npc = p4;
    end
    check_eq("pc_plus4", pc_plus4, p4);
    if (exc) m_epc = m_pc;
    m_pc  = npc;
    m_ret = m_ret + 32'd1;
    e.pc = m_pc; e.epc = m_epc; e.retired = m_ret; e.exc = exc;
    e.halted = x_halt && !exc;
    sb_q.push_back(e);
    ex_done = 1'b1;
    step();
    clear_ctrl();
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("done_pc", pc, e.pc);
      check_eq("done_epc", epc, e.epc);
      check_eq("done_retired", retired, e.retired);
      check_eq("done_exc_taken", {31'd0, exc_taken}, {31'd0, e.exc});
      check_eq("done_halted", {31'd0, halted}, {31'd0, e.halted});
      check_eq("done_req", {31'd0, imem_req}, {31'd0, !e.halted});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pc"}, pc, T_RESET_PC);
    check_eq({tag, "_addr"}, imem_addr, T_RESET_PC);
    check_eq({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check_eq({tag, "_ir"}, ir, 32'd0);
    check_eq({tag, "_epc"}, epc, 32'd0);
    check_eq({tag, "_retired"}, retired, 32'd0);
    check_eq({tag, "_exc"}, {31'd0, exc_taken}, 32'd0);
    check_eq({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0000_0000;
    clear_ctrl();
    model_reset();
    step();
    step();
    reset = 1'b0;
    check_reset_state("rst");

    do_fetch(0, 32'h2008_0005);
    do_exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 16'h0000, 1'b0);       // 3004
    do_fetch(0, 32'h1111_0001);
    do_exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 16'hFFFE, 1'b0);       // 3000
    do_fetch(0, 32'h1111_0002);
    do_exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 16'h0003, 1'b0);       // 3010
    do_fetch(0, 32'h0800_0C10);
    do_exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h000_0C10, 1'b1, 16'h0004, 1'b0); // 3040
    do_fetch(5, 32'h0000_000C);
    do_exec(0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 16'h0000, 1'b0);       // exc
    do_fetch(0, 32'h4200_0018);
    do_exec(3, 1'b0, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 26'd0, 1'b0, 16'h0000, 1'b0); // eret
    do_fetch(0, 32'h0040_0008);
    do_exec(0, 1'b0, 1'b0, 1'b1, 32'h0000_3042, 1'b0, 26'd0, 1'b0, 16'h0000, 1'b0); // misaligned jr
    do_fetch(1, 32'h0040_0008);
    do_exec(0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 26'h000_0001, 1'b0, 16'h0000, 1'b0);
    do_fetch(0, 32'h0000_0000);
    do_exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 16'h0000, 1'b0);       // wraps to 0
    do_fetch(0, 32'h0C00_0123);
    do_exec(0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h3FF_FFFF, 1'b0, 16'h0000, 1'b0);
    do_fetch(0, 32'h0000_000C);
    do_exec(0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 16'h0000, 1'b1);       // exc beats halt
    do_fetch(0, 32'h0000_000D);
    do_exec(2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 16'h0000, 1'b1);       // halt

    imem_ack = 1'b1;
    ex_done  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("halt_req_low", {31'd0, imem_req}, 32'd0);
      check_eq("halt_flag", {31'd0, halted}, 32'd1);
      check_eq("halt_pc", pc, m_pc);
    end
    imem_ack = 1'b0;
    ex_done  = 1'b0;

    reset = 1'b1;
    #1;
    model_reset();
    check_reset_state("rst_halt");
    step();
    reset = 1'b0;
    do_fetch(0, 32'h2008_0005);
    reset = 1'b1;
    #1;
    check_reset_state("rst_exec");
    step();
    reset = 1'b0;
    do_fetch(2, 32'h2008_0006);
    do_exec(1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 16'h8000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
